// File: rtl/pcm_ring_pkg.sv
// Purpose: shared constants for the PCM ring writer: CSR word addresses and CTRL/STATUS bit positions.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pcm_ring_pkg;

  // CSR word addresses
  localparam logic [1:0] CSR_CTRL   = 2'd0;
  localparam logic [1:0] CSR_STATUS = 2'd1;
  localparam logic [1:0] CSR_WRPTR  = 2'd2;
  localparam logic [1:0] CSR_RDPTR  = 2'd3;

  // CTRL bit positions
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_DROP   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_FLUSH  = 3;

  // STATUS bit positions
  localparam int STAT_WM_PEND = 0;
  localparam int STAT_OVERRUN = 1;

  // Offset of the multi-bit fields (watermark, level) inside CTRL/STATUS
  localparam int FIELD_OFS = 16;

endpackage

// File: rtl/pcm_ring_csr.sv
// Purpose: CSR register file for the ring writer: CTRL, STATUS (W1C flags), WR_PTR view, RD_PTR.
// Latency: writes take effect at the strobe edge; readdata registered, 1 cycle after csr_read.
// Backpressure: none; the slave accepts every access without wait states.
// Ports: csr_* Avalon-MM slave; wr_ptr/level/wm_set/overrun_set in from datapath;
//        enable/drop_mode/irq_en/flush/watermark/rd_ptr out to datapath; irq level interrupt.
module pcm_ring_csr #(
  parameter int ADDR_W   = 11,
  parameter int WM_RESET = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [1:0]        csr_address,
  input  logic              csr_read,
  input  logic              csr_write,
  input  logic [31:0]       csr_writedata,
  output logic [31:0]       csr_readdata,
  input  logic [ADDR_W-1:0] wr_ptr,
  input  logic [ADDR_W-1:0] level,
  input  logic              wm_set,
  input  logic              overrun_set,
  output logic              enable,
  output logic              drop_mode,
  output logic              irq_en,
  output logic              flush,
  output logic [ADDR_W-1:0] watermark,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic              irq
);
  import pcm_ring_pkg::*;

  logic        wm_pend;
  logic        overrun;
  logic        ctrl_wr;
  logic        stat_wr;
  logic        rdptr_wr;
  logic [31:0] rd_mux;
  logic        unused_wdata;

  assign ctrl_wr  = csr_write && (csr_address == CSR_CTRL);
  assign stat_wr  = csr_write && (csr_address == CSR_STATUS);
  assign rdptr_wr = csr_write && (csr_address == CSR_RDPTR);

  // Flush is a single-cycle strobe straight from the write; it is never stored.
  assign flush = ctrl_wr && csr_writedata[CTRL_FLUSH];

  // Only some write-data bits are mapped.
  assign unused_wdata = ^csr_writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable    <= 1'b0;
      drop_mode <= 1'b0;
      irq_en    <= 1'b0;
      watermark <= ADDR_W'(WM_RESET);
    end else if (ctrl_wr) begin
      enable    <= csr_writedata[CTRL_ENABLE];
      drop_mode <= csr_writedata[CTRL_DROP];
      irq_en    <= csr_writedata[CTRL_IRQ_EN];
      watermark <= csr_writedata[FIELD_OFS +: ADDR_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
    end else if (rdptr_wr) begin
      rd_ptr <= csr_writedata[ADDR_W-1:0];
    end
  end

  // Flag priority: flush clears, then a hardware set beats a same-cycle W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wm_pend <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (flush)                                    wm_pend <= 1'b0;
      else if (wm_set)                              wm_pend <= 1'b1;
      else if (stat_wr && csr_writedata[STAT_WM_PEND]) wm_pend <= 1'b0;

      if (flush)                                    overrun <= 1'b0;
      else if (overrun_set)                         overrun <= 1'b1;
      else if (stat_wr && csr_writedata[STAT_OVERRUN]) overrun <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (csr_address)
      CSR_CTRL: begin
        rd_mux[CTRL_ENABLE]          = enable;
        rd_mux[CTRL_DROP]            = drop_mode;
        rd_mux[CTRL_IRQ_EN]          = irq_en;
        rd_mux[FIELD_OFS +: ADDR_W]  = watermark;
      end
      CSR_STATUS: begin
        rd_mux[STAT_WM_PEND]         = wm_pend;
        rd_mux[STAT_OVERRUN]         = overrun;
        rd_mux[FIELD_OFS +: ADDR_W]  = level;
      end
      CSR_WRPTR: rd_mux[ADDR_W-1:0]  = wr_ptr;
      default:   rd_mux[ADDR_W-1:0]  = rd_ptr;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      csr_readdata <= '0;
    end else if (csr_read) begin
      csr_readdata <= rd_mux;
    end
  end

  assign irq = wm_pend & irq_en;

endmodule

// File: rtl/pcm_ring_writer.sv
// Purpose: writes a valid/ready PCM sample stream into port 2 of a dual-port ring memory, with CSRs.
// Latency: memory write issues 1 cycle after accept; 1 sample/cycle sustained.
// Backpressure: snk_ready = enable, and additionally ~full unless drop mode discards on full.
// Ports: clk/reset_n; snk_* sample sink; mem_* memory port 2 master; csr_* CSR slave; irq.
module pcm_ring_writer #(
  parameter int ADDR_W   = 11,
  parameter int DATA_W   = 16,
  parameter int WM_RESET = 1024
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DATA_W-1:0]   snk_data,
  input  logic                snk_valid,
  output logic                snk_ready,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  input  logic [1:0]          csr_address,
  input  logic                csr_read,
  input  logic                csr_write,
  input  logic [31:0]         csr_writedata,
  output logic [31:0]         csr_readdata,
  output logic                irq
);
  import pcm_ring_pkg::*;

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W-1:0] level;
  logic [ADDR_W-1:0] watermark;
  logic              enable;
  logic              drop_mode;
  logic              irq_en;
  logic              flush;
  logic              full;
  logic              accept;
  logic              do_write;
  logic              wm_set;
  logic              overrun_set;

  // Natural wrap of the ADDR_W-bit subtraction gives the modulo-DEPTH level.
  assign level = wr_ptr - rd_ptr;
  // One slot stays empty so full (DEPTH-1) and empty (0) stay distinguishable.
  assign full  = &level;

  assign snk_ready   = enable & (drop_mode | ~full);
  assign accept      = snk_valid & snk_ready;
  assign do_write    = accept & ~full;
  assign overrun_set = accept & full;
  assign wm_set      = (watermark != '0) && (level >= watermark);

  // A write accepted on a flush cycle still lands at the pre-flush address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
    end else if (do_write) begin
      wr_ptr <= wr_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      mem_write <= do_write;
      if (do_write) begin
        mem_address   <= wr_ptr;
        mem_writedata <= snk_data;
      end
    end
  end

  assign mem_chipselect = mem_write;
  assign mem_byteenable = '1;
  assign mem_clken      = 1'b1;

  pcm_ring_csr #(
    .ADDR_W   (ADDR_W),
    .WM_RESET (WM_RESET)
  ) u_csr (
    .clk           (clk),
    .reset_n       (reset_n),
    .csr_address   (csr_address),
    .csr_read      (csr_read),
    .csr_write     (csr_write),
    .csr_writedata (csr_writedata),
    .csr_readdata  (csr_readdata),
    .wr_ptr        (wr_ptr),
    .level         (level),
    .wm_set        (wm_set),
    .overrun_set   (overrun_set),
    .enable        (enable),
    .drop_mode     (drop_mode),
    .irq_en        (irq_en),
    .flush         (flush),
    .watermark     (watermark),
    .rd_ptr        (rd_ptr),
    .irq           (irq)
  );

endmodule

// File: tb/tb_pcm_ring_writer.sv
// Purpose: self-checking bench for pcm_ring_writer: vector table, directed corner sequences, random run.
// Latency: checks every output 1 ns after each rising edge against a reference model.
// Backpressure: sink valid is driven independently of snk_ready, as a real source would.
module tb_pcm_ring_writer;

  localparam int DEPTH = 2048;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [15:0] snk_data = '0;
  logic        snk_valid = 1'b0;
  logic        snk_ready;
  logic [10:0] mem_address;
  logic [15:0] mem_writedata;
  logic [1:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic        mem_clken;
  logic [1:0]  csr_address = '0;
  logic        csr_read = 1'b0;
  logic        csr_write = 1'b0;
  logic [31:0] csr_writedata = '0;
  logic [31:0] csr_readdata;
  logic        irq;

  int n_chk = 0;
  int n_fail = 0;

  pcm_ring_writer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .snk_data       (snk_data),
    .snk_valid      (snk_valid),
    .snk_ready      (snk_ready),
    .mem_address    (mem_address),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_clken      (mem_clken),
    .csr_address    (csr_address),
    .csr_read       (csr_read),
    .csr_write      (csr_write),
    .csr_writedata  (csr_writedata),
    .csr_readdata   (csr_readdata),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  // Reference model state: pointers as plain integers, flags as bits.
  int          m_wr, m_rd, m_wm, m_paddr;
  bit          m_en, m_drop, m_irqen, m_wmp, m_ovr, m_pw;
  logic [15:0] m_pdata;
  logic [31:0] m_rdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_level();
    return (m_wr - m_rd + DEPTH) % DEPTH;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_wm = 1024; m_paddr = 0;
    m_en = 0; m_drop = 0; m_irqen = 0; m_wmp = 0; m_ovr = 0; m_pw = 0;
    m_pdata = '0; m_rdata = '0;
  endtask

  // One clock: predict from current inputs + model, advance, compare all outputs.
  task automatic step();
    int lvl;
    bit full, rdy, fire, wfire, ctrl_w, st_w, rd_w, flush, wm_hit;
    logic [31:0] nrd;
    lvl    = m_level();
    full   = (lvl == DEPTH - 1);
    rdy    = m_en && (m_drop || !full);
    fire   = snk_valid && rdy;
    wfire  = fire && !full;
    ctrl_w = csr_write && csr_address == 2'd0;
    st_w   = csr_write && csr_address == 2'd1;
    rd_w   = csr_write && csr_address == 2'd3;
    flush  = ctrl_w && csr_writedata[3];
    wm_hit = (m_wm != 0) && (lvl >= m_wm);
    nrd = m_rdata;
    if (csr_read) begin
      case (csr_address)
        2'd0: nrd = 32'(m_en) | (32'(m_drop) << 1) | (32'(m_irqen) << 2) | (32'(m_wm) << 16);
        2'd1: nrd = 32'(m_wmp) | (32'(m_ovr) << 1) | (32'(lvl) << 16);
        2'd2: nrd = 32'(m_wr);
        default: nrd = 32'(m_rd);
      endcase
    end
    @(posedge clk);
    #1;
    m_rdata = nrd;
    m_pw = wfire;
    if (wfire) begin
      m_paddr = m_wr;
      m_pdata = snk_data;
    end
    if (flush) m_wmp = 0;
    else if (wm_hit) m_wmp = 1;
    else if (st_w && csr_writedata[0]) m_wmp = 0;
    if (flush) m_ovr = 0;
    else if (fire && full) m_ovr = 1;
    else if (st_w && csr_writedata[1]) m_ovr = 0;
    if (ctrl_w) begin
      m_en    = csr_writedata[0];
      m_drop  = csr_writedata[1];
      m_irqen = csr_writedata[2];
      m_wm    = int'(csr_writedata[26:16]);
    end
    if (flush) m_wr = 0;
    else if (wfire) m_wr = (m_wr + 1) % DEPTH;
    if (flush) m_rd = 0;
    else if (rd_w) m_rd = int'(csr_writedata[10:0]);

    chk("snk_ready", 32'(snk_ready), 32'(m_en && (m_drop || m_level() != DEPTH - 1)));
    chk("irq", 32'(irq), 32'(m_wmp && m_irqen));
    chk("mem_write", 32'(mem_write), 32'(m_pw));
    chk("mem_chipselect", 32'(mem_chipselect), 32'(m_pw));
    if (m_pw) begin
      chk("mem_address", 32'(mem_address), 32'(m_paddr));
      chk("mem_writedata", 32'(mem_writedata), 32'(m_pdata));
    end
    chk("csr_readdata", csr_readdata, m_rdata);
  endtask

  task automatic csr_wr(input logic [1:0] a, input logic [31:0] d);
    csr_write = 1'b1; csr_address = a; csr_writedata = d;
    step();
    csr_write = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] a, output logic [31:0] d);
    csr_read = 1'b1; csr_address = a;
    step();
    csr_read = 1'b0;
    d = csr_readdata;
  endtask

  task automatic do_reset();
    snk_valid = 1'b0; csr_read = 1'b0; csr_write = 1'b0;
    reset_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic        wr;
    logic        rd;
    logic [1:0]  a;
    logic [31:0] wd;
    logic        e_rdy;
    logic        e_w;
    logic [10:0] e_addr;
    logic [15:0] e_dat;
    logic        e_chk;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int n;

    #3;
    do_reset();

    // Reset state
    chk("rst snk_ready", 32'(snk_ready), 32'd0);
    chk("rst mem_write", 32'(mem_write), 32'd0);
    chk("rst mem_chipselect", 32'(mem_chipselect), 32'd0);
    chk("rst irq", 32'(irq), 32'd0);
    chk("rst mem_address", 32'(mem_address), 32'd0);
    chk("rst mem_writedata", 32'(mem_writedata), 32'd0);
    chk("rst csr_readdata", csr_readdata, 32'd0);
    chk("mem_byteenable", 32'(mem_byteenable), 32'd3);
    chk("mem_clken", 32'(mem_clken), 32'd1);

    // Four back-to-back samples, then pointer/status reads
    //            v  d         wr rd a     wd            rdy w  addr   dat       chk rdata
    tbl[0] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd0, 32'h0, 1'b0, 1'b0, 11'd0, 16'h0000, 1'b1, 32'h0400_0000};
    tbl[1] = '{1'b0, 16'h0000, 1'b1, 1'b0, 2'd0, 32'h0400_0001, 1'b1, 1'b0, 11'd0, 16'h0000, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 16'h1111, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 11'd0, 16'h1111, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 16'h2222, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 11'd1, 16'h2222, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 16'h3333, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 11'd2, 16'h3333, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 16'h4444, 1'b0, 1'b0, 2'd0, 32'h0, 1'b1, 1'b1, 11'd3, 16'h4444, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd2, 32'h0, 1'b1, 1'b0, 11'd0, 16'h0000, 1'b1, 32'd4};
    tbl[7] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd1, 32'h0, 1'b1, 1'b0, 11'd0, 16'h0000, 1'b1, 32'h0004_0000};
    tbl[8] = '{1'b0, 16'h0000, 1'b0, 1'b1, 2'd3, 32'h0, 1'b1, 1'b0, 11'd0, 16'h0000, 1'b1, 32'd0};
    for (int i = 0; i < 9; i++) begin
      snk_valid = tbl[i].v; snk_data = tbl[i].d;
      csr_write = tbl[i].wr; csr_read = tbl[i].rd;
      csr_address = tbl[i].a; csr_writedata = tbl[i].wd;
      step();
      chk($sformatf("tbl%0d snk_ready", i), 32'(snk_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("tbl%0d mem_write", i), 32'(mem_write), 32'(tbl[i].e_w));
      if (tbl[i].e_w) begin
        chk($sformatf("tbl%0d mem_address", i), 32'(mem_address), 32'(tbl[i].e_addr));
        chk($sformatf("tbl%0d mem_writedata", i), 32'(mem_writedata), 32'(tbl[i].e_dat));
      end
      if (tbl[i].e_chk) chk($sformatf("tbl%0d csr_readdata", i), csr_readdata, tbl[i].e_rdata);
    end
    snk_valid = 1'b0; csr_write = 1'b0; csr_read = 1'b0;

    // Backpressure fill to DEPTH-1, then free 10 slots and wrap
    csr_wr(2'd0, 32'h0400_0009);
    snk_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 2100 && snk_ready; i++) begin
      snk_data = 16'($urandom);
      step();
      n++;
    end
    chk("fill accepts", 32'(n), 32'd2047);
    chk("full snk_ready", 32'(snk_ready), 32'd0);
    snk_valid = 1'b0;
    csr_rd(2'd1, rd);
    chk("full level", 32'(rd[26:16]), 32'd2047);
    snk_valid = 1'b1;
    csr_wr(2'd3, 32'd10);
    chk("rdptr ready", 32'(snk_ready), 32'd1);
    for (int k = 0; k < 10; k++) begin
      snk_data = 16'($urandom);
      step();
      chk("wrap mem_write", 32'(mem_write), 32'd1);
      chk("wrap mem_address", 32'(mem_address), 32'((2047 + k) % DEPTH));
    end
    chk("refull snk_ready", 32'(snk_ready), 32'd0);

    // Drop mode overrun and W1C vs. set race
    snk_valid = 1'b0;
    csr_wr(2'd0, 32'h0400_0003);
    snk_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      snk_data = 16'($urandom);
      step();
      chk("drop mem_write", 32'(mem_write), 32'd0);
    end
    snk_valid = 1'b0;
    csr_rd(2'd2, rd);
    chk("drop wr_ptr", rd, 32'd9);
    csr_rd(2'd1, rd);
    chk("overrun set", 32'(rd[1]), 32'd1);
    csr_wr(2'd1, 32'h2);
    csr_rd(2'd1, rd);
    chk("overrun w1c", 32'(rd[1]), 32'd0);
    snk_valid = 1'b1;
    csr_wr(2'd1, 32'h2);
    snk_valid = 1'b0;
    csr_rd(2'd1, rd);
    chk("overrun set wins", 32'(rd[1]), 32'd1);

    // Watermark 8 with irq enabled
    csr_wr(2'd0, 32'h0008_000D);
    chk("flush irq", 32'(irq), 32'd0);
    for (int k = 0; k < 8; k++) begin
      snk_valid = 1'b1; snk_data = 16'($urandom);
      step();
      chk("wm irq low", 32'(irq), 32'd0);
    end
    snk_valid = 1'b0;
    step();
    chk("wm irq rise", 32'(irq), 32'd1);
    csr_wr(2'd1, 32'h1);
    chk("wm w1c held", 32'(irq), 32'd1);
    csr_wr(2'd3, 32'd4);
    chk("wm rdptr irq", 32'(irq), 32'd1);
    csr_wr(2'd1, 32'h1);
    chk("wm w1c clear", 32'(irq), 32'd0);
    snk_valid = 1'b1;
    repeat (4) step();
    snk_valid = 1'b0;
    step();
    chk("wm irq again", 32'(irq), 32'd1);

    // Asynchronous reset while a write is on the bus
    snk_valid = 1'b1;
    step();
    chk("pre-rst mem_write", 32'(mem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("async mem_write", 32'(mem_write), 32'd0);
    chk("async snk_ready", 32'(snk_ready), 32'd0);
    chk("async irq", 32'(irq), 32'd0);
    do_reset();
    csr_rd(2'd2, rd);
    chk("post-rst wr_ptr", rd, 32'd0);

    // Flush on the same cycle as an accept
    csr_wr(2'd0, 32'h0400_0001);
    snk_valid = 1'b1;
    repeat (3) step();
    snk_data = 16'hABCD;
    csr_wr(2'd0, 32'h0400_0009);
    chk("flush mem_write", 32'(mem_write), 32'd1);
    chk("flush mem_address", 32'(mem_address), 32'd3);
    chk("flush mem_writedata", 32'(mem_writedata), 32'h0000_ABCD);
    snk_valid = 1'b0;
    csr_rd(2'd2, rd);
    chk("flush wr_ptr", rd, 32'd0);
    csr_rd(2'd1, rd);
    chk("flush status", rd, 32'd0);
    snk_valid = 1'b1; snk_data = 16'h5A5A;
    step();
    chk("post-flush addr", 32'(mem_address), 32'd0);

    // Random traffic against the model
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      csr_write = 1'b0; csr_read = 1'b0;
      snk_valid = ($urandom_range(0, 3) != 0);
      snk_data  = 16'($urandom);
      if (r < 15) begin
        csr_write = 1'b1; csr_address = 2'd3;
        csr_writedata = 32'((m_rd + int'($urandom_range(0, m_level()))) % DEPTH);
      end else if (r < 18) begin
        csr_write = 1'b1; csr_address = 2'd1;
        csr_writedata = 32'($urandom_range(0, 3));
      end else if (r < 20) begin
        csr_write = 1'b1; csr_address = 2'd0;
        csr_writedata = 32'($urandom_range(0, 40)) << 16;
        csr_writedata[0] = ($urandom_range(0, 7) != 0);
        csr_writedata[1] = 1'($urandom_range(0, 1));
        csr_writedata[2] = 1'($urandom_range(0, 1));
        csr_writedata[3] = ($urandom_range(0, 9) == 0);
      end else if (r < 35) begin
        csr_read = 1'b1; csr_address = 2'($urandom_range(0, 3));
      end
      step();
    end
    csr_write = 1'b0; csr_read = 1'b0; snk_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pcm_ring_writer.md
Name: pcm_ring_writer

Overview:
- Stream-to-memory stage for captured PCM samples. Accepts 16-bit samples on a valid/ready sink and writes them, one per cycle, into the second port (s2) of the 2048x16 dual-port on-chip sample memory, treated as a ring buffer.
- The Nios CPU drains the buffer through port s1 and reports progress by writing a read pointer. A small Avalon-MM CSR slave exposes control, status, pointers and a fill-level watermark interrupt.

Parameters:
- ADDR_W, 11, ring address width; DEPTH = 2**ADDR_W words.
- DATA_W, 16, sample and memory word width (byteenable width DATA_W/8).
- WM_RESET, 1024, reset value of the watermark threshold.

Ports:
- clk  in  1  system clock; all logic is single-clock.
- reset_n  in  1  asynchronous, active-low reset.
- snk_data  in  DATA_W  PCM sample.
- snk_valid  in  1  sample valid.
- snk_ready  out  1  sample accepted when valid&ready.
- mem_address  out  ADDR_W  to memory address2.
- mem_writedata  out  DATA_W  to writedata2.
- mem_byteenable  out  DATA_W/8  to byteenable2; tied all-ones.
- mem_chipselect  out  1  to chipselect2.
- mem_write  out  1  to write2.
- mem_clken  out  1  to clken2; tied 1.
- csr_address  in  2  CSR word address.
- csr_read  in  1  CSR read strobe.
- csr_write  in  1  CSR write strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data; read latency 1, registered.
- irq  out  1  level interrupt.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - snk_ready, mem_write, mem_chipselect, irq = 0; mem_address, mem_writedata, csr_readdata = 0.
  - wr_ptr = rd_ptr = 0; CTRL = enable 0, drop 0, irq_en 0, WM = WM_RESET; STATUS flags = 0.
- CSR map:
  - 0 CTRL RW: bit0 enable, bit1 drop_mode, bit2 irq_en, bit3 flush (write-1, self-clearing, reads 0), bits[16+ADDR_W-1:16] watermark.
  - 1 STATUS: bit0 wm_pend (W1C), bit1 overrun (W1C), bits[16+ADDR_W-1:16] level (RO).
  - 2 WR_PTR: RO.
  - 3 RD_PTR: RW, ADDR_W bits, upper bits ignored.
  - Unmapped bits read 0.
- Level and full:
  - level = (wr_ptr - rd_ptr) mod DEPTH.
  - full when level == DEPTH-1; one slot is always left unused.
- snk_ready:
  - Drop mode: snk_ready = enable.
  - Backpressure mode: snk_ready = enable & ~full.
  - snk_ready is combinational from registers only, never from snk_valid.
- Accept (valid&ready, not full) at edge N:
  - mem_address <= wr_ptr; mem_writedata <= snk_data; mem_write = mem_chipselect = 1 for exactly the following cycle.
  - wr_ptr <= wr_ptr+1, wrapping DEPTH-1 -> 0.
  - Write latency is 1 cycle; sustained throughput is 1 sample/cycle.
- Accept while full (drop mode only): no memory write, wr_ptr unchanged, overrun <= 1.
- Watermark: wm_pend <= 1 on any cycle where level >= watermark and watermark != 0. irq = wm_pend & irq_en.
- Simultaneous events:
  - Hardware set and W1C on the same cycle: set wins.
  - RD_PTR write and sample accept on the same cycle: both take effect; level uses the new values next cycle.
- Flush: wr_ptr, rd_ptr <= 0 and overrun, wm_pend <= 0. A write already registered still issues next cycle at its old address.
- Clearing enable: snk_ready falls the next cycle. A registered pending write completes; no state is lost.
- Software keeps rd_ptr within the valid ring. An rd_ptr written "ahead" of wr_ptr is simply interpreted modulo DEPTH.

Decomposition:
- Package pcm_ring_pkg holds:
  - CSR address constants (CSR_CTRL=0, CSR_STATUS=1, CSR_WRPTR=2, CSR_RDPTR=3).
  - CTRL/STATUS bit-index constants and the field offset 16.
- One sub-module is natural: pcm_ring_csr, holding the register file, W1C logic and the readdata register. It exports enable, drop_mode, irq_en, flush pulse, watermark and rd_ptr, and imports wr_ptr, level and the set pulses.
- The datapath and pointer logic stay in the top module.

Test Plan:
- Reset, then enable=1 and 4 samples 0x1111..0x4444 back-to-back → mem_write high on 4 consecutive cycles, addresses 0..3, each one cycle after its accept; WR_PTR reads 4.
- Backpressure mode, no reads, stream 2047 samples → snk_ready drops after 2047 accepts; STATUS level = 2047; writing RD_PTR = 10 restores snk_ready and allows 10 more writes at addresses 2047, 0..8 (wrap).
- Drop mode, buffer full, 5 extra valid samples → no mem_write, wr_ptr unchanged, overrun = 1; W1C on STATUS bit1 clears it; W1C asserted on the same cycle as a new drop leaves it set.
- Watermark = 8, irq_en = 1 → irq rises on the cycle after level reaches 8; W1C of wm_pend while level >= 8 keeps irq set; after RD_PTR is advanced so level < 8, W1C clears irq.
- Assert reset_n low mid-stream while mem_write = 1 → mem_write, snk_ready and irq fall immediately (asynchronously); WR_PTR reads 0 after release.
- Flush with a write pending → that write issues at its old address; WR_PTR = 0 and level = 0 next cycle; the next sample is written at address 0.
